dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port 256x8 data memory (combinational read, write on posedge Clk).
- Requester A is the core load/store unit and has priority. Requester B is a secondary master (DMA/init loader) and is protected by a starvation guard.
- A may lock the memory across consecutive accesses for atomic read-modify-write.
- The block drives the memory's WriteEn/DataAddress/DataIn and returns registered read data to each requester.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          AReq;
  logic          AWe;
  logic [AW-1:0] AAddr;
  logic [DW-1:0] AData;
  logic          ALock;
  logic          AGnt;
  logic [DW-1:0] ARData;
  logic          ARValid;

  logic          BReq;
  logic          BWe;
  logic [AW-1:0] BAddr;
  logic [DW-1:0] BData;
  logic          BGnt;
  logic [DW-1:0] BRData;
  logic          BRValid;

  logic          MemWriteEn;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemDataIn;
  logic [DW-1:0] MemDataOut;

  modport slave (
    input  AReq, AWe, AAddr, AData, ALock,
    output AGnt, ARData, ARValid,
    input  BReq, BWe, BAddr, BData,
    output BGnt, BRData, BRValid,
    output MemWriteEn, MemAddr, MemDataIn,
    input  MemDataOut
  );

  modport master (
    output AReq, AWe, AAddr, AData, ALock,
    input  AGnt, ARData, ARValid,
    output BReq, BWe, BAddr, BData,
    input  BGnt, BRData, BRValid,
    input  MemWriteEn, MemAddr, MemDataIn,
    output MemDataOut
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the 256x8 data memory: A has priority and may lock, B has a starvation guard.
// Optional grant/conflict counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 8,
  parameter int DW       = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]    AGntCnt,
  output logic [15:0]    BGntCnt,
  output logic [15:0]    ConflictCnt
`endif
);

  typedef enum logic {LK_OPEN, LK_HELD} lock_e;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  lock_e         lock_q, lock_d;
  logic [3:0]    wait_q, wait_d;
  logic          a_gnt, b_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] ardata_q, brdata_q;
  logic          arvalid_q, brvalid_q;

  // Grant decision plus lock and starvation-counter next state.
  always_comb begin
    a_gnt  = 1'b0;
    b_gnt  = 1'b0;
    lock_d = lock_q;
    wait_d = wait_q;
    // Reset low gates every grant so nothing reaches the memory mid-reset.
    if (Reset) begin
      if (lock_q == LK_HELD)                   a_gnt = bus.AReq;
      else if (bus.BReq && wait_q == WAIT_MAX) b_gnt = 1'b1;
      else if (bus.AReq)                       a_gnt = 1'b1;
      else if (bus.BReq)                       b_gnt = 1'b1;
    end
    if (a_gnt)
      lock_d = bus.ALock ? LK_HELD : LK_OPEN;
    else if (lock_q == LK_HELD && !bus.AReq)
      lock_d = LK_OPEN;
    // Frozen while locked so releasing a lock does not immediately hand the bus to B.
    if (b_gnt || !bus.BReq)
      wait_d = 4'd0;
    else if (lock_q == LK_OPEN && wait_q != WAIT_MAX)
      wait_d = wait_q + 4'd1;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (a_gnt) begin
      mem_we   = bus.AWe;
      mem_addr = bus.AAddr;
      mem_din  = bus.AData;
    end else if (b_gnt) begin
      mem_we   = bus.BWe;
      mem_addr = bus.BAddr;
      mem_din  = bus.BData;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lock_q    <= LK_OPEN;
      wait_q    <= 4'd0;
      ardata_q  <= '0;
      brdata_q  <= '0;
      arvalid_q <= 1'b0;
      brvalid_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      wait_q    <= wait_d;
      arvalid_q <= a_gnt && !bus.AWe;
      brvalid_q <= b_gnt && !bus.BWe;
      if (a_gnt && !bus.AWe) ardata_q <= bus.MemDataOut;
      if (b_gnt && !bus.BWe) brdata_q <= bus.MemDataOut;
    end
  end

  assign bus.AGnt       = a_gnt;
  assign bus.BGnt       = b_gnt;
  assign bus.MemWriteEn = mem_we;
  assign bus.MemAddr    = mem_addr;
  assign bus.MemDataIn  = mem_din;
  assign bus.ARData     = ardata_q;
  assign bus.ARValid    = arvalid_q;
  assign bus.BRData     = brdata_q;
  assign bus.BRValid    = brvalid_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] agnt_cnt_q, bgnt_cnt_q, conflict_cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      agnt_cnt_q     <= '0;
      bgnt_cnt_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (a_gnt && agnt_cnt_q != 16'hFFFF)                          agnt_cnt_q     <= agnt_cnt_q + 16'd1;
      if (b_gnt && bgnt_cnt_q != 16'hFFFF)                          bgnt_cnt_q     <= bgnt_cnt_q + 16'd1;
      if (bus.AReq && bus.BReq && conflict_cnt_q != 16'hFFFF)       conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign AGntCnt     = agnt_cnt_q;
  assign BGntCnt     = bgnt_cnt_q;
  assign ConflictCnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked against a behavioural model
// that also owns a shadow copy of the memory contents.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic pl_go = 1'b0;
  int unsigned seed;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] AGntCnt, BGntCnt, ConflictCnt;
`endif

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .AGntCnt     (AGntCnt),
    .BGntCnt     (BGntCnt),
    .ConflictCnt (ConflictCnt)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 73 + int'(seed)) ^ (a >> 3));
  endfunction

  // Memory: combinational read, write on posedge; one-shot preload during reset.
  logic [7:0] mem [256];
  always @(posedge Clk) begin
    if (pl_go) for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    else if (bus.MemWriteEn) mem[bus.MemAddr] <= bus.MemDataIn;
  end
  assign bus.MemDataOut = mem[bus.MemAddr];

  // Reference model state
  logic [7:0] ref_mem [256];
  int  m_lock, m_wait;
  logic [7:0] m_ardata, m_brdata;
  bit  m_arvalid, m_brvalid;
  int  m_acnt, m_bcnt, m_ccnt;
  bit  exp_agnt, exp_bgnt, exp_we;
  logic [7:0] exp_addr, exp_din;
  bit  c_ar, c_aw, c_al, c_br, c_bw;
  logic [7:0] c_aa, c_ad, c_ba, c_bd;
  int  n_cmp = 0, n_fail = 0;

  task automatic drive(input bit ar, input bit aw, input logic [7:0] aa, input logic [7:0] ad, input bit al,
                       input bit br, input bit bw, input logic [7:0] ba, input logic [7:0] bd);
    c_ar = ar; c_aw = aw; c_aa = aa; c_ad = ad; c_al = al;
    c_br = br; c_bw = bw; c_ba = ba; c_bd = bd;
    bus.AReq = ar; bus.AWe = aw; bus.AAddr = aa; bus.AData = ad; bus.ALock = al;
    bus.BReq = br; bus.BWe = bw; bus.BAddr = ba; bus.BData = bd;
    exp_agnt = 0; exp_bgnt = 0;
    if (Reset) begin
      if (m_lock != 0) exp_agnt = ar;
      else if (br && m_wait >= MAX_WAIT) exp_bgnt = 1;
      else if (ar) exp_agnt = 1;
      else if (br) exp_bgnt = 1;
    end
    exp_we   = exp_agnt ? aw : (exp_bgnt ? bw : 1'b0);
    exp_addr = exp_agnt ? aa : (exp_bgnt ? ba : 8'h00);
    exp_din  = exp_agnt ? ad : (exp_bgnt ? bd : 8'h00);
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
  endtask

  // Advance one clock and apply the architectural effect of this cycle to the model.
  task automatic tick();
    @(posedge Clk);
    if (!Reset) begin
      m_lock = 0; m_wait = 0; m_ardata = 0; m_brdata = 0; m_arvalid = 0; m_brvalid = 0;
      m_acnt = 0; m_bcnt = 0; m_ccnt = 0;
    end else begin
      m_arvalid = exp_agnt && !c_aw;
      m_brvalid = exp_bgnt && !c_bw;
      if (m_arvalid) m_ardata = ref_mem[c_aa];
      if (m_brvalid) m_brdata = ref_mem[c_ba];
      if (exp_we) ref_mem[exp_addr] = exp_din;
      if (exp_agnt) $display("txn t=%0t A %s addr=%02h data=%02h lock=%0d", $time, c_aw ? "W" : "R", c_aa, c_aw ? c_ad : ref_mem[c_aa], c_al);
      if (exp_bgnt) $display("txn t=%0t B %s addr=%02h data=%02h", $time, c_bw ? "W" : "R", c_ba, c_bw ? c_bd : ref_mem[c_ba]);
      if (exp_bgnt || !c_br) m_wait = 0;
      else if (m_lock == 0 && m_wait < MAX_WAIT) m_wait++;
      if (exp_agnt) m_lock = c_al;
      else if (m_lock != 0 && !c_ar) m_lock = 0;
      if (exp_agnt && m_acnt < 65535) m_acnt++;
      if (exp_bgnt && m_bcnt < 65535) m_bcnt++;
      if (c_ar && c_br && m_ccnt < 65535) m_ccnt++;
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    logic [7:0] prior;
    drive(1, 1, 8'h10, 8'hAA, 0, 1, 1, 8'h11, 8'h55);
    n_cmp++; if (bus.AGnt !== 1'b0 || bus.BGnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got A=%b B=%b want 0 0", bus.AGnt, bus.BGnt); end
    n_cmp++; if (bus.MemWriteEn !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.MemWriteEn); end
    n_cmp++; if (bus.ARValid !== 1'b0 || bus.BRValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got A=%b B=%b want 0 0", bus.ARValid, bus.BRValid); end
    n_cmp++; if (bus.ARData !== 8'h00 || bus.BRData !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got A=%02h B=%02h want 00 00", bus.ARData, bus.BRData); end
    @(negedge Clk);
    Reset = 1'b1;
    idle(); tick();
    prior = ref_mem[8'h10];
    drive(1, 1, 8'h10, 8'hAA, 0, 0, 0, 8'h00, 8'h00);
    n_cmp++; if (bus.AGnt !== 1'b1) begin n_fail++; $display("FAIL pre_reset_gnt: got %b want 1", bus.AGnt); end
    Reset = 1'b0;
    #1;
    n_cmp++; if (bus.AGnt !== 1'b0 || bus.MemWriteEn !== 1'b0) begin n_fail++; $display("FAIL midreset_gate: got AGnt=%b We=%b want 0 0", bus.AGnt, bus.MemWriteEn); end
    tick();
    Reset = 1'b1;
    drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    tick();
    idle();
    n_cmp++; if (bus.ARValid !== 1'b1 || bus.ARData !== prior) begin n_fail++; $display("FAIL reset_nowrite: got v=%b d=%02h want 1 %02h", bus.ARValid, bus.ARData, prior); end
    n_cmp++; if (bus.ARData !== init_byte(16)) begin n_fail++; $display("FAIL reset_prior: got %02h want %02h", bus.ARData, init_byte(16)); end
    tick();
  endtask

  task automatic test_write_read();
    drive(1, 1, 8'h20, 8'h5C, 0, 0, 0, 8'h00, 8'h00);
    n_cmp++; if (bus.AGnt !== 1'b1 || bus.MemWriteEn !== 1'b1 || bus.MemAddr !== 8'h20 || bus.MemDataIn !== 8'h5C) begin
      n_fail++; $display("FAIL wr_cycle: got g=%b we=%b a=%02h d=%02h want 1 1 20 5c", bus.AGnt, bus.MemWriteEn, bus.MemAddr, bus.MemDataIn); end
    tick();
    drive(1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    n_cmp++; if (bus.AGnt !== 1'b1 || bus.ARValid !== 1'b0) begin n_fail++; $display("FAIL rd_cycle: got g=%b v=%b want 1 0", bus.AGnt, bus.ARValid); end
    tick();
    idle();
    n_cmp++; if (bus.ARValid !== 1'b1 || bus.ARData !== 8'h5C) begin n_fail++; $display("FAIL raw_data: got v=%b d=%02h want 1 5c", bus.ARValid, bus.ARData); end
    tick();
    n_cmp++; if (bus.ARValid !== 1'b0 || bus.ARData !== 8'h5C) begin n_fail++; $display("FAIL rvalid_pulse: got v=%b d=%02h want 0 5c", bus.ARValid, bus.ARData); end
  endtask

  task automatic test_starvation();
    bit want_b;
    idle(); tick();
    for (int c = 1; c <= 6; c++) begin
      drive(1, 0, 8'($urandom), 8'h00, 0, 1, 0, 8'($urandom), 8'h00);
      want_b = (c == 5);
      n_cmp++; if (bus.AGnt !== !want_b || bus.BGnt !== want_b) begin
        n_fail++; $display("FAIL starve_c%0d: got A=%b B=%b want A=%b B=%b", c, bus.AGnt, bus.BGnt, !want_b, want_b); end
      tick();
    end
    idle();
    n_cmp++; if (bus.ARValid !== 1'b1 || bus.ARData !== m_ardata) begin n_fail++; $display("FAIL starve_rd: got v=%b d=%02h want 1 %02h", bus.ARValid, bus.ARData, m_ardata); end
    tick();
  endtask

  task automatic test_lock();
    logic [7:0] bval;
    bval = 8'($urandom);
    drive(1, 0, 8'h30, 8'h00, 1, 1, 1, 8'h31, bval);
    n_cmp++; if (bus.AGnt !== 1'b1 || bus.BGnt !== 1'b0) begin n_fail++; $display("FAIL lock_c1: got A=%b B=%b want 1 0", bus.AGnt, bus.BGnt); end
    tick();
    drive(1, 1, 8'h30, 8'h77, 0, 1, 1, 8'h31, bval);
    n_cmp++; if (bus.AGnt !== 1'b1 || bus.BGnt !== 1'b0) begin n_fail++; $display("FAIL lock_c2: got A=%b B=%b want 1 0", bus.AGnt, bus.BGnt); end
    n_cmp++; if (bus.ARValid !== 1'b1 || bus.ARData !== init_byte(48)) begin n_fail++; $display("FAIL lock_rd: got v=%b d=%02h want 1 %02h", bus.ARValid, bus.ARData, init_byte(48)); end
    tick();
    drive(0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h31, bval);
    n_cmp++; if (bus.AGnt !== 1'b0 || bus.BGnt !== 1'b1 || bus.MemAddr !== 8'h31) begin n_fail++; $display("FAIL lock_after: got A=%b B=%b a=%02h want 0 1 31", bus.AGnt, bus.BGnt, bus.MemAddr); end
    tick();
    idle(); tick();
  endtask

  task automatic test_lock_drop();
    drive(1, 0, 8'h40, 8'h00, 1, 1, 0, 8'h41, 8'h00);
    n_cmp++; if (bus.AGnt !== 1'b1 || bus.BGnt !== 1'b0) begin n_fail++; $display("FAIL drop_c1: got A=%b B=%b want 1 0", bus.AGnt, bus.BGnt); end
    tick();
    drive(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h41, 8'h00);
    n_cmp++; if (bus.AGnt !== 1'b0 || bus.BGnt !== 1'b0) begin n_fail++; $display("FAIL drop_c2: got A=%b B=%b want 0 0", bus.AGnt, bus.BGnt); end
    tick();
    drive(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h41, 8'h00);
    n_cmp++; if (bus.BGnt !== 1'b1) begin n_fail++; $display("FAIL drop_c3: got B=%b want 1", bus.BGnt); end
    tick();
    idle();
    n_cmp++; if (bus.BRValid !== 1'b1 || bus.BRData !== init_byte(65)) begin n_fail++; $display("FAIL drop_rd: got v=%b d=%02h want 1 %02h", bus.BRValid, bus.BRData, init_byte(65)); end
    tick();
  endtask

  task automatic test_random();
    bit ap = 0, bp = 0, aw = 0, al = 0, bw = 0;
    logic [7:0] aa = 0, ad = 0, ba = 0, bd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ap && $urandom_range(99) < 60) begin
        ap = 1; aw = $urandom_range(1); al = ($urandom_range(99) < 30);
        aa = 8'($urandom_range(15)); ad = 8'($urandom);
      end
      if (!bp && $urandom_range(99) < 50) begin
        bp = 1; bw = $urandom_range(1); ba = 8'($urandom_range(15)); bd = 8'($urandom);
      end
      drive(ap, aw, aa, ad, al, bp, bw, ba, bd);
      n_cmp++; if (bus.AGnt !== exp_agnt || bus.BGnt !== exp_bgnt) begin
        n_fail++; $display("FAIL rnd_gnt[%0d]: got A=%b B=%b want A=%b B=%b", i, bus.AGnt, bus.BGnt, exp_agnt, exp_bgnt); end
      n_cmp++; if (bus.MemWriteEn !== exp_we || bus.MemAddr !== exp_addr || bus.MemDataIn !== exp_din) begin
        n_fail++; $display("FAIL rnd_mem[%0d]: got we=%b a=%02h d=%02h want %b %02h %02h", i, bus.MemWriteEn, bus.MemAddr, bus.MemDataIn, exp_we, exp_addr, exp_din); end
      n_cmp++; if (bus.ARValid !== m_arvalid || bus.ARData !== m_ardata) begin
        n_fail++; $display("FAIL rnd_ar[%0d]: got v=%b d=%02h want %b %02h", i, bus.ARValid, bus.ARData, m_arvalid, m_ardata); end
      n_cmp++; if (bus.BRValid !== m_brvalid || bus.BRData !== m_brdata) begin
        n_fail++; $display("FAIL rnd_br[%0d]: got v=%b d=%02h want %b %02h", i, bus.BRValid, bus.BRData, m_brvalid, m_brdata); end
      if (exp_agnt) ap = 0;
      if (exp_bgnt) bp = 0;
      tick();
    end
    idle(); tick();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    int a0, b0, c0;
    idle(); tick();
    a0 = m_acnt; b0 = m_bcnt; c0 = m_ccnt;
    for (int c = 0; c < 3; c++) begin drive(1, 0, 8'h50, 8'h00, 0, 1, 0, 8'h51, 8'h00); tick(); end
    idle(); tick();
    for (int c = 0; c < 2; c++) begin drive(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h52, 8'h00); tick(); end
    idle();
    n_cmp++; if (int'(ConflictCnt) - c0 !== 3) begin n_fail++; $display("FAIL stats_conf: got delta %0d want 3", int'(ConflictCnt) - c0); end
    n_cmp++; if (int'(BGntCnt) - b0 !== 2) begin n_fail++; $display("FAIL stats_b: got delta %0d want 2", int'(BGntCnt) - b0); end
    n_cmp++; if (int'(AGntCnt) - a0 !== 3) begin n_fail++; $display("FAIL stats_a: got delta %0d want 3", int'(AGntCnt) - a0); end
    n_cmp++; if (AGntCnt !== 16'(m_acnt) || BGntCnt !== 16'(m_bcnt) || ConflictCnt !== 16'(m_ccnt)) begin
      n_fail++; $display("FAIL stats_total: got %0d %0d %0d want %0d %0d %0d", AGntCnt, BGntCnt, ConflictCnt, m_acnt, m_bcnt, m_ccnt); end
    tick();
  endtask
`endif

  initial begin
    seed = $urandom;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    m_lock = 0; m_wait = 0; m_ardata = 0; m_brdata = 0; m_arvalid = 0; m_brvalid = 0;
    m_acnt = 0; m_bcnt = 0; m_ccnt = 0;
    Reset = 1'b0;
    idle();
    pl_go = 1'b1;
    @(posedge Clk);
    #1 pl_go = 1'b0;
    @(negedge Clk);
    test_reset();
    test_write_read();
    test_starvation();
    test_lock();
    test_lock_drop();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
